button_reader: RTL and testbench

//  Memory-mapped input peripheral, the CPU-read counterpart of the LED output register.

---
 rtl/button_reader_pkg.sv | 26 ++
 rtl/button_reader_debounce_filter.sv | 49 ++++
 rtl/button_reader.sv | 66 ++++++
 tb/tb_button_reader.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/button_reader_pkg.sv
// Shared bit positions for the button status word and the CPU clear word.
// The CPU address map uses these same constants.
package button_reader_pkg;

    localparam int ST_LEVEL    = 0;
    localparam int ST_PRESS    = 1;
    localparam int ST_RELEASE  = 2;
    localparam int ST_CNT_LSB  = 8;
    localparam int ST_CNT_W    = 8;

    localparam int CLR_PRESS   = 1;
    localparam int CLR_RELEASE = 2;
    localparam int CLR_COUNT   = 3;

    function automatic logic [15:0] pack_status(input logic level, input logic press,
                                                input logic rel, input logic [7:0] cnt);
        logic [15:0] s;
        s = '0;
        s[ST_LEVEL]                 = level;
        s[ST_PRESS]                 = press;
        s[ST_RELEASE]               = rel;
        s[ST_CNT_LSB +: ST_CNT_W]   = cnt;
        return s;
    endfunction

endpackage

// File: rtl/button_reader_debounce_filter.sv
// Two-flop synchroniser followed by a run-length debouncer; emits one-cycle
// rise/fall strobes on the same edge the debounced level changes.
module debounce_filter #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign accept = (sync2 != stable) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    // NOTE: reset is synchronous (sampled at the clock edge) and all state uses <=.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any return to the stable level discards accumulated progress.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level = stable;
    assign rise  = accept &  sync2;
    assign fall  = accept & ~sync2;

endmodule

// File: rtl/button_reader.sv
// Memory-mapped push-button reader: debounced level, sticky press/release
// flags and an 8-bit press counter, cleared by CPU writes.
module button_reader
    import button_reader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn,
    input  logic        load,
    input  logic [15:0] in,
    output logic [15:0] out
);

    logic       level;
    logic       rise;
    logic       fall;
    logic       press_flag;
    logic       rel_flag;
    logic [7:0] press_cnt;
    logic       clr_press;
    logic       clr_release;
    logic       clr_count;
    logic       unused_in;

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    assign clr_press   = load & in[CLR_PRESS];
    assign clr_release = load & in[CLR_RELEASE];
    assign clr_count   = load & in[CLR_COUNT];
    assign unused_in   = ^{in[15:4], in[0]};

    // An event arriving in the same cycle as a clear takes priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            press_flag <= 1'b0;
            rel_flag   <= 1'b0;
            press_cnt  <= '0;
        end else begin
            press_flag <= rise | (press_flag & ~clr_press);
            rel_flag   <= fall | (rel_flag   & ~clr_release);
            if (clr_count) begin
                press_cnt <= rise ? 8'd1 : 8'd0;
            end else if (rise) begin
                press_cnt <= press_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        out = pack_status(level, press_flag, rel_flag, press_cnt);
    end

endmodule

// File: tb/tb_button_reader.sv
// Self-checking bench for button_reader with DEBOUNCE_CYCLES=4: a window-based
// reference model checked every cycle plus hand-computed directed checks.
module tb_button_reader;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn = 1'b1;
    logic        load = 1'b0;
    logic [15:0] in = 16'h0000;
    logic [15:0] out;

    int n_checks = 0;
    int n_pass   = 0;

    button_reader #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .load  (load),
        .in    (in),
        .out   (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // Reference model: the level flips once the last D synchronised samples
    // (btn as seen two edges late) all disagree with the current level.
    bit         hist[$];
    bit         m_valid = 1'b0;
    bit         m_level, m_pf, m_rf;
    logic [7:0] m_cnt;
    logic [15:0] exp_out;

    always @(posedge clk) begin
        bit all_diff, m_rise, m_fall;
        if (!rst_n) begin
            m_valid = 1'b1;
            hist.delete();
            repeat (D + 1) hist.push_back(1'b0);
            m_level = 1'b0;
            m_pf    = 1'b0;
            m_rf    = 1'b0;
            m_cnt   = 8'h00;
        end else if (m_valid) begin
            all_diff = 1'b1;
            for (int k = 1; k <= D; k++)
                if (hist[hist.size() - 1 - k] == m_level) all_diff = 1'b0;
            m_rise = all_diff && !m_level;
            m_fall = all_diff &&  m_level;
            if (all_diff) m_level = !m_level;
            if (m_rise) m_pf = 1'b1;
            else if (load && in[1]) m_pf = 1'b0;
            if (m_fall) m_rf = 1'b1;
            else if (load && in[2]) m_rf = 1'b0;
            if (load && in[3]) m_cnt = m_rise ? 8'd1 : 8'd0;
            else if (m_rise) m_cnt = m_cnt + 8'd1;
            hist.push_back(btn);
            void'(hist.pop_front());
        end
        exp_out = {m_cnt, 5'b00000, m_rf, m_pf, m_level};
    end

    always @(negedge clk) begin
        if (m_valid) check("model", out, exp_out);
    end

    task automatic hold(input bit b, input int n);
        btn = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic write(input logic [15:0] v);
        load = 1'b1;
        in   = v;
        @(negedge clk);
        load = 1'b0;
        in   = 16'h0000;
    endtask

    initial begin
        // Reset with the button held high, then measure acceptance latency.
        repeat (2) @(negedge clk);
        check("reset_out", out, 16'h0000);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("latency_early", {15'b0, out[0]}, 16'h0000);
        @(negedge clk);
        check("latency_exact", out, 16'h0103);
        hold(1'b0, 10);
        check("first_release", out, 16'h0106);
        write(16'h000E);
        check("clear_all", out, 16'h0000);

        // Short pulse is rejected.
        hold(1'b1, 3);
        hold(1'b0, 10);
        check("glitch_reject", out, 16'h0000);

        // Bouncing edge counts as one press.
        hold(1'b1, 1);
        hold(1'b0, 1);
        hold(1'b1, 1);
        hold(1'b0, 1);
        hold(1'b1, 10);
        check("bounce_press", out, 16'h0103);
        hold(1'b0, 10);
        check("bounce_release", out, 16'h0106);
        write(16'h000E);

        // Five clean presses, then clear both flags only.
        for (int i = 0; i < 5; i++) begin
            hold(1'b1, 8);
            hold(1'b0, 8);
        end
        check("five_presses", out, 16'h0506);
        write(16'h0006);
        check("clear_flags", out, 16'h0500);

        // Clear of flag and count coinciding with an accepted press.
        btn = 1'b1;
        repeat (5) @(negedge clk);
        write(16'h000A);
        check("event_wins", out, 16'h0103);
        hold(1'b0, 8);
        write(16'h000E);
        check("clear_again", out, 16'h0000);

        // Counter wraps after 256 presses; flag stays set.
        for (int i = 0; i < 256; i++) begin
            hold(1'b1, 7);
            hold(1'b0, 7);
            if (i == 254) check("count_ff", out, 16'hFF06);
        end
        check("count_wrap", out, 16'h0006);

        // Reset in the middle of debouncing a held press, with a write pending.
        hold(1'b1, 3);
        rst_n = 1'b0;
        load  = 1'b1;
        in    = 16'h000E;
        @(negedge clk);
        check("reset_mid", out, 16'h0000);
        rst_n = 1'b1;
        load  = 1'b0;
        in    = 16'h0000;
        repeat (5) @(negedge clk);
        check("reacq_early", {15'b0, out[0]}, 16'h0000);
        @(negedge clk);
        check("reacq_exact", out, 16'h0103);
        hold(1'b0, 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
